// File: rtl/scratchpad_responder.sv
// Single-port-pair scratchpad: registered read with write-first bypass, one write
// per cycle, optional zeroing sweep after reset, sticky out-of-range flag.
module scratchpad_responder #(
  parameter int data_size      = 16,
  parameter int addr_size      = 14,
  parameter int depth          = 16384,
  parameter bit clear_on_reset = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [addr_size-1:0] rd_address,
  output logic [data_size-1:0] rd_data,
  input  logic                 wr_enable,
  input  logic [addr_size-1:0] wr_address,
  input  logic [data_size-1:0] wr_data,
  output logic                 busy,
  output logic                 addr_error
);

  localparam int          idx_w   = (depth > 1) ? $clog2(depth) : 1;
  localparam logic [31:0] depth_u = 32'(depth);
  localparam logic [31:0] last_u  = 32'(depth - 1);

  typedef enum logic {CLEAR, READY} state_t;

  state_t               state_q, state_d;
  logic [addr_size-1:0] clr_cnt_q, clr_cnt_d;

  logic [data_size-1:0] mem [depth];

  logic                 ready_p0;
  logic                 rd_ok_p0;
  logic                 wr_ok_p0;
  logic                 wr_hit_p0;
  logic                 mem_we_p0;
  logic [idx_w-1:0]     mem_idx_p0;
  logic [data_size-1:0] mem_wdata_p0;
  logic [data_size-1:0] rd_next_p0;
  logic                 err_set_p0;

  // stage p0: address decode, write arbitration, read mux
  always_comb begin
    ready_p0     = (state_q == READY);
    rd_ok_p0     = (32'(rd_address) < depth_u);
    wr_ok_p0     = (32'(wr_address) < depth_u);
    wr_hit_p0    = ready_p0 && wr_enable && wr_ok_p0;
    // Gating on reset drops a write whose edge lands while reset is held.
    mem_we_p0    = reset && ((state_q == CLEAR) || wr_hit_p0);
    mem_idx_p0   = (state_q == CLEAR) ? clr_cnt_q[idx_w-1:0] : wr_address[idx_w-1:0];
    mem_wdata_p0 = (state_q == CLEAR) ? '0 : wr_data;
    rd_next_p0   = '0;
    if (ready_p0 && rd_ok_p0) begin
      if (wr_hit_p0 && (rd_address == wr_address)) rd_next_p0 = wr_data;
      else                                         rd_next_p0 = mem[rd_address[idx_w-1:0]];
    end
    err_set_p0   = ready_p0 && (!rd_ok_p0 || (wr_enable && !wr_ok_p0));
  end

  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    if (state_q == CLEAR) begin
      clr_cnt_d = clr_cnt_q + 1'b1;
      if (32'(clr_cnt_q) == last_u) begin
        state_d   = READY;
        clr_cnt_d = '0;
      end
    end
  end

  // stage p1: storage array and registered outputs
  always_ff @(posedge clk) begin
    if (mem_we_p0) mem[mem_idx_p0] <= mem_wdata_p0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= clear_on_reset ? CLEAR : READY;
      clr_cnt_q  <= '0;
      rd_data    <= '0;
      addr_error <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_cnt_q  <= clr_cnt_d;
      rd_data    <= rd_next_p0;
      if (err_set_p0) addr_error <= 1'b1;
    end
  end

  assign busy = (state_q == CLEAR);

endmodule

// File: doc/scratchpad_responder.md
Name: scratchpad_responder

Overview:
- Single-clock on-chip scratchpad that answers the memory accesses issued by the element-wise compute sequencers (vector add, copy, etc.).
- One registered read port serves operand fetches; one write port accepts result stores.
- Optional power-on clear sweep; read-during-write bypass; sticky out-of-range flag.
- Sits between the layer sequencers and the feature-map storage.

Parameters:
- data_size, 16, width of each stored word and of rd_data/wr_data.
- addr_size, 14, width of rd_address/wr_address.
- depth, 16384, number of words; legal addresses 0..depth-1, depth <= 2^addr_size.
- clear_on_reset, 1, 1 = zero every word after reset before accepting accesses; 0 = no sweep, contents retained across reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset.
- rd_address  input  addr_size  read word address, sampled every rising edge.
- rd_data  output  data_size  registered read data.
- wr_enable  input  1  level write strobe; one write per rising edge while high.
- wr_address  input  addr_size  write word address.
- wr_data  input  data_size  write data.
- busy  output  1  high while the clear sweep runs; accesses not serviced.
- addr_error  output  1  sticky: an out-of-range read or write was seen.

Behaviour:
- Reset (reset=0, async): rd_data=0, addr_error=0, clear counter=0.
  - clear_on_reset=1: state=CLEAR, busy=1.
  - clear_on_reset=0: state=READY, busy=0.
  - Array contents are not touched asynchronously.
- States: CLEAR, READY.
  - CLEAR: each edge writes 0 to mem[counter] and increments counter. At counter==depth-1 the last word is written and the state goes to READY. Sweep takes exactly depth cycles after reset release.
  - During CLEAR: external writes dropped, rd_data held 0, addr_error not updated.
  - READY: terminal until next reset.
- Read (READY): at each edge, rd_data <= mem[rd_address].
  - Latency 1 edge: an address held from edge k-1 gives valid data after edge k.
  - Sequencers that wait 2+ cycles after driving an address always sample settled data.
  - No enable on the read port.
- Write (READY): at each edge with wr_enable=1 and wr_address<depth, mem[wr_address] <= wr_data.
  - wr_enable held high across cycles rewrites every cycle; last value per address wins.
  - A cycle where address updates before data (stale data to new address) is legal and is overwritten by the next write.
- Same-address read and write in one edge: write-first; rd_data <= wr_data.
- Different addresses in one edge: both complete independently.
- Out of range (address >= depth):
  - Read returns 0 and sets addr_error.
  - Write is dropped and sets addr_error.
  - Addresses are never wrapped.
  - addr_error clears only on reset.
- Reset asserted mid-sweep: the sweep restarts from 0 on release.
- Reset asserted mid-write (clear_on_reset=0): the write in flight at the reset edge is lost; other words are kept.
- Widths: no arithmetic on data; address compare is unsigned and zero-extended to 32 bits.

Test Plan:
1. depth=16, clear_on_reset=1: release reset, then read addr 5 every cycle.
   - busy=1 for exactly 16 cycles.
   - rd_data=0 during and after the sweep.
   - A write of 0xBEEF to addr 3 during the sweep is dropped: a later read of 3 returns 0.
2. Write 0x0010 to addr 100 and 0x0020 to addr 200, then emulate the vector-add sequencer: drive addr 100, wait 2 cycles, sample; drive addr 200, wait 2, sample.
   - Samples are 0x0010 and 0x0020.
   - A store of 0x0030 to addr 300, read back, returns 0x0030.
3. Same edge: wr addr 7 = 0x1234, rd addr 7 (old value 0x0001).
   - rd_data=0x1234 after that edge.
   - Same edge with rd addr 8 instead returns the prior mem[8].
4. wr_enable held high while wr_address changes 40->41 one cycle before wr_data changes 0xAAAA->0x5555.
   - Final mem[40]=0xAAAA, mem[41]=0x5555.
5. depth=1000: read addr 1000.
   - rd_data=0 and addr_error=1.
   - A write to 1023 is dropped and addr_error stays 1.
   - Legal accesses still work.
   - Reset clears addr_error.
6. clear_on_reset=0: write 0xCAFE to addr 9, pulse reset for 1 cycle, read addr 9.
   - busy stays 0.
   - rd_data=0xCAFE.
   - With clear_on_reset=1, reset mid-sweep at cycle 8 restarts the sweep: busy stays high for a full depth cycles after release.
